bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//   Two-requester round-robin arbiter sharing one BRAM port (512x16 default).
//   Accepts at most one read/write per cycle, drives a single-cycle en/we/addr/din beat.
//   Returns read data to the issuing requester after a fixed read latency.
//   Sits between test/control FSMs and BRAM port A; port B is left free for independent readback.
// PARAMETERS
//   AW      9   BRAM address width (depth 2**AW)
//   DW      16  data width
//   RD_LAT  2   cycles from mem_en cycle to the cycle mem_dout is sampled; legal 1..4
// PORTS
//   clk            in   1      single clock, all logic posedge
//   rst            in   1      synchronous reset, active-high
//   req[1:0]       in   2      per-requester access request, level
//   we[1:0]        in   2      per-requester write(1)/read(0)
//   addr0, addr1   in   AW     per-requester address
//   wdata0, wdata1 in   DW     per-requester write data
//   gnt[1:0]       out  2      combinational grant; access accepted in cycle req[i]&gnt[i]
//   rvalid[1:0]    out  2      1-cycle read-return pulse, registered
//   rdata          out  DW     read data, valid while any rvalid bit is high
//   mem_en         out  1      BRAM enable, registered
//   mem_we         out  1      BRAM write enable, registered
//   mem_addr       out  AW     BRAM address, registered
//   mem_din        out  DW     BRAM write data, registered
//   mem_dout       in   DW     BRAM read data
//   conflict_cnt   out  16     cycles with both req high (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst sampled high): gnt=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0,
//     mem_din=0, conflict_cnt=0, prio ptr=0, read-tag pipeline cleared.
//     In-flight reads are dropped; no rvalid is issued for them after reset.
//   Arbitration (combinational, from req and ptr):
//     - only req[i] high -> gnt[i]=1
//     - both high -> gnt[ptr]=1, the other stays 0
//     - none high -> gnt=0
//     - gnt is never high while rst is high.
//   ptr update: on accept by i, ptr <= ~i. Unchanged on idle cycles.
//     Alternation under continuous contention: 0,1,0,1...
//   Requester contract:
//     - hold we/addr/wdata stable while req is high and gnt is low
//     - dropping req before gnt is legal; no access occurs
//   Accept in cycle C -> mem_en=1 with the winner's we/addr/wdata in cycle C+1 only.
//     No accept -> mem_en=0, mem_we=0; mem_addr and mem_din hold.
//   Fully pipelined: one accept per cycle sustained, back-to-back from either requester.
//   Reads: the 1-bit owner tag plus a valid bit enter an RD_LAT-deep shift pipeline.
//     In cycle C+1+RD_LAT: rvalid[owner]=1 and rdata=mem_dout sampled that cycle.
//     rdata holds its last value when rvalid=0.
//   Writes: no response pulse; ordering is issue order.
//     A read accepted after a write to the same address returns the new data.
//   rvalid[0] and rvalid[1] are never high together.
//   Address wrap: none; addr is passed through unmodified and the full range 0..2**AW-1 is legal.
// CONFIGURATION
//   BRAM_ARB_CONFLICT_CNT_EN defined:
//     - conflict_cnt increments in every cycle with req==2'b11 and rst low
//     - saturates at 16'hFFFF; cleared only by rst
//   Not defined: conflict_cnt tied to 16'h0000 and no counter logic is built.
//   Arbitration and timing are identical either way.
// TESTING
//   1. Reset: hold rst 3 cycles with req=11 -> gnt=00, mem_en=0, rvalid=00; all outputs zero.
//   2. R0 writes 16'h1234 @9'd508 (accept C), then R0 reads @508 at C+1
//      -> mem_en high C+1 and C+2; rvalid=01 and rdata=16'h1234 at C+4 (RD_LAT=2).
//   3. req=11 held 6 cycles, reads @0 (R0) and @511 (R1)
//      -> gnt sequence 01,10,01,10,01,10; each requester gets 3 rvalid pulses, in issue order.
//   4. R1 reads @1 and R0 reads @2 back-to-back with BRAM preloaded 16'h0005/16'h0006
//      -> rvalid 10 then 01 on consecutive cycles, rdata 16'h0005 then 16'h0006.
//   5. Read accepted, rst pulsed 1 cycle at C+1 -> no rvalid in C+3/C+4; ptr=0 afterwards.
//   6. BRAM_ARB_CONFLICT_CNT_EN defined, req=11 for 10 cycles -> conflict_cnt=10.
//      Same run without the macro -> conflict_cnt=0.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// ============================================================================
// Module : bram_port_arbiter_if
// Brief  : Requester-side bus of the two-port BRAM arbiter (req/we/addr/wdata
//          in, gnt/rvalid/rdata out).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bram_port_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 16
);
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1,
        output gnt, rvalid, rdata
    );
endinterface

`default_nettype wire

// File: rtl/bram_port_arbiter.sv
// ============================================================================
// Module : bram_port_arbiter
// Brief  : Round-robin arbiter sharing one BRAM port between two requesters,
//          with tagged read-return pipeline. Optional conflict counter built
//          when BRAM_ARB_CONFLICT_CNT_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_port_arbiter #(
    parameter int AW     = 9,
    parameter int DW     = 16,
    parameter int RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    bram_port_arbiter_if.slave   bus,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_din,
    input  logic [DW-1:0]        mem_dout,
    output logic [15:0]          conflict_cnt
);

    logic              r_ptr;
    logic [1:0]        w_gnt;
    logic              w_accept;
    logic              w_sel;
    logic              w_sel_we;
    logic [AW-1:0]     w_sel_addr;
    logic [DW-1:0]     w_sel_wdata;
    logic [RD_LAT-1:0] r_rd_vld;
    logic [RD_LAT-1:0] r_rd_tag;
    logic [1:0]        r_rvalid;
    logic [DW-1:0]     r_rdata;

    // Grant is suppressed during reset so nothing is accepted in that cycle.
    always_comb begin
        w_gnt = 2'b00;
        if (!rst) begin
            case (bus.req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_ptr ? 2'b10 : 2'b01;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign bus.gnt     = w_gnt;
    assign w_accept    = |w_gnt;
    assign w_sel       = w_gnt[1];
    assign w_sel_we    = w_sel ? bus.we[1]  : bus.we[0];
    assign w_sel_addr  = w_sel ? bus.addr1  : bus.addr0;
    assign w_sel_wdata = w_sel ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            r_rd_vld <= '0;
            r_rd_tag <= '0;
            r_rvalid <= 2'b00;
            r_rdata  <= '0;
        end else begin
            mem_en <= w_accept;
            mem_we <= w_accept & w_sel_we;
            if (w_accept) begin
                mem_addr <= w_sel_addr;
                mem_din  <= w_sel_wdata;
                r_ptr    <= ~w_sel;
            end
            // Owner tag rides alongside the read so the return is steered correctly.
            for (int k = RD_LAT - 1; k > 0; k--) begin
                r_rd_vld[k] <= r_rd_vld[k-1];
                r_rd_tag[k] <= r_rd_tag[k-1];
            end
            r_rd_vld[0] <= w_accept & ~w_sel_we;
            r_rd_tag[0] <= w_sel;
            r_rvalid    <= r_rd_vld[RD_LAT-1] ?
                           (r_rd_tag[RD_LAT-1] ? 2'b10 : 2'b01) : 2'b00;
            if (r_rd_vld[RD_LAT-1]) begin
                r_rdata <= mem_dout;
            end
        end
    end

    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = r_rdata;

`ifdef BRAM_ARB_CONFLICT_CNT_EN
    logic [15:0] r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict_cnt <= 16'h0000;
        end else if (bus.req == 2'b11 && r_conflict_cnt != 16'hFFFF) begin
            r_conflict_cnt <= r_conflict_cnt + 16'h0001;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`else
    assign conflict_cnt = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
// ============================================================================
// Module : tb_bram_port_arbiter
// Brief  : Directed self-checking bench for bram_port_arbiter with a
//          one-cycle registered BRAM model (RD_LAT=2).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_port_arbiter;

    localparam int AW     = 9;
    localparam int DW     = 16;
    localparam int RD_LAT = 2;
`ifdef BRAM_ARB_CONFLICT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic [15:0]   conflict_cnt;
    logic [DW-1:0] bram [0:511];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    bram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .conflict_cnt (conflict_cnt)
    );

    // Read-first BRAM, one-cycle registered output.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_din;
            mem_dout <= bram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bus.req    = req;
        bus.we     = we;
        bus.addr0  = a0;
        bus.addr1  = a1;
        bus.wdata0 = d0;
        bus.wdata1 = d1;
    endtask

    logic [1:0]    exp_rv;
    logic [DW-1:0] exp_rd;

    initial begin
        // 1: reset held with contention
        rst = 1'b1;
        drive(2'b11, 2'b00, '0, '0, '0, '0);
        for (int j = 0; j < 3; j++) begin
            step();
            @(negedge clk);
            check("t1_gnt", bus.gnt, 2'b00);
            check("t1_mem_en", mem_en, 1'b0);
            check("t1_rvalid", bus.rvalid, 2'b00);
        end
        check("t1_rdata", bus.rdata, 16'h0);
        check("t1_mem_we", mem_we, 1'b0);
        check("t1_mem_addr", mem_addr, 9'h0);
        check("t1_mem_din", mem_din, 16'h0);
        check("t1_cnt", conflict_cnt, 16'h0);
        step();
        rst = 1'b0;
        drive(2'b00, 2'b00, '0, '0, '0, '0);

        // 2: R0 write then read of the same address
        step();
        drive(2'b01, 2'b01, 9'd508, '0, 16'h1234, '0);
        @(negedge clk);
        check("t2_gnt_wr", bus.gnt, 2'b01);
        step();
        drive(2'b01, 2'b00, 9'd508, '0, '0, '0);
        @(negedge clk);
        check("t2_gnt_rd", bus.gnt, 2'b01);
        check("t2_en1", mem_en, 1'b1);
        check("t2_we1", mem_we, 1'b1);
        check("t2_addr1", mem_addr, 9'd508);
        check("t2_din1", mem_din, 16'h1234);
        step();
        drive(2'b00, 2'b00, '0, '0, '0, '0);
        @(negedge clk);
        check("t2_en2", mem_en, 1'b1);
        check("t2_we2", mem_we, 1'b0);
        check("t2_addr2", mem_addr, 9'd508);
        step();
        @(negedge clk);
        check("t2_en3", mem_en, 1'b0);
        check("t2_rv_early", bus.rvalid, 2'b00);
        check("t2_addr_hold", mem_addr, 9'd508);
        step();
        @(negedge clk);
        check("t2_rvalid", bus.rvalid, 2'b01);
        check("t2_rdata", bus.rdata, 16'h1234);
        step();
        @(negedge clk);
        check("t2_rv_off", bus.rvalid, 2'b00);
        check("t2_rdata_hold", bus.rdata, 16'h1234);

        // 3: preload @0 and @511, then six cycles of contention
        step();
        drive(2'b01, 2'b01, 9'd0, '0, 16'hA0A0, '0);
        step();
        drive(2'b10, 2'b10, '0, 9'd511, '0, 16'hB1B1);
        @(negedge clk);
        check("t3_pre_gnt", bus.gnt, 2'b10);
        step();
        drive(2'b00, 2'b00, '0, '0, '0, '0);
        for (int j = 0; j < 10; j++) begin
            step();
            drive((j < 6) ? 2'b11 : 2'b00, 2'b00, 9'd0, 9'd511, '0, '0);
            @(negedge clk);
            if (j < 6) check("t3_gnt", bus.gnt, (j % 2 == 0) ? 2'b01 : 2'b10);
            exp_rv = (j >= 3 && j <= 8) ? (((j - 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_rd = ((j - 3) % 2 == 0) ? 16'hA0A0 : 16'hB1B1;
            check("t3_rvalid", bus.rvalid, exp_rv);
            if (exp_rv != 2'b00) check("t3_rdata", bus.rdata, exp_rd);
        end
        check("t3_cnt", conflict_cnt, CNT_EN ? 16'd6 : 16'd0);

        // 4: preload @1/@2, then R1 reads @1 and R0 reads @2 back-to-back
        for (int j = 0; j < 8; j++) begin
            step();
            case (j)
                0:       drive(2'b01, 2'b01, 9'd1, '0, 16'h0005, '0);
                1:       drive(2'b01, 2'b01, 9'd2, '0, 16'h0006, '0);
                2:       drive(2'b10, 2'b00, '0, 9'd1, '0, '0);
                3:       drive(2'b01, 2'b00, 9'd2, '0, '0, '0);
                default: drive(2'b00, 2'b00, '0, '0, '0, '0);
            endcase
            @(negedge clk);
            if (j == 2) check("t4_gnt_r1", bus.gnt, 2'b10);
            if (j == 3) check("t4_gnt_r0", bus.gnt, 2'b01);
            exp_rv = (j == 5) ? 2'b10 : (j == 6) ? 2'b01 : 2'b00;
            check("t4_rvalid", bus.rvalid, exp_rv);
            if (j == 5) check("t4_rdata1", bus.rdata, 16'h0005);
            if (j == 6) check("t4_rdata2", bus.rdata, 16'h0006);
        end

        // 5: read accepted, then 1-cycle reset drops it and clears ptr
        step();
        drive(2'b01, 2'b00, 9'd508, '0, '0, '0);
        @(negedge clk);
        check("t5_gnt", bus.gnt, 2'b01);
        step();
        rst = 1'b1;
        drive(2'b00, 2'b00, '0, '0, '0, '0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t5_rv_c2", bus.rvalid, 2'b00);
        check("t5_mem_en", mem_en, 1'b0);
        check("t5_cnt_clr", conflict_cnt, 16'h0);
        check("t5_rdata_clr", bus.rdata, 16'h0);
        for (int j = 0; j < 3; j++) begin
            step();
            @(negedge clk);
            check("t5_rv_dropped", bus.rvalid, 2'b00);
        end
        step();
        drive(2'b11, 2'b00, '0, '0, '0, '0);
        @(negedge clk);
        check("t5_ptr", bus.gnt, 2'b01);
        drive(2'b00, 2'b00, '0, '0, '0, '0);

        // 6: ten cycles of contention feed the conflict counter
        for (int j = 0; j < 10; j++) begin
            step();
            drive(2'b11, 2'b00, 9'd3, 9'd4, '0, '0);
            @(negedge clk);
            check("t6_gnt", bus.gnt, (j % 2 == 0) ? 2'b01 : 2'b10);
        end
        step();
        drive(2'b00, 2'b00, '0, '0, '0, '0);
        @(negedge clk);
        check("t6_cnt", conflict_cnt, CNT_EN ? 16'd10 : 16'd0);
        repeat (4) step();
        @(negedge clk);
        check("t6_cnt_hold", conflict_cnt, CNT_EN ? 16'd10 : 16'd0);
        check("t6_idle_rv", bus.rvalid, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
